uart_op_sequencer: RTL
======================

Name: uart_op_sequencer

Overview:
- Sequences the UART-fed arithmetic datapath on the iCE40 debugger top level.
- Collects operand bytes from the UART receiver and presents them to the LUT/carry adder chain.
- Waits the adder's settle latency, then hands the result bytes to the UART transmitter over a valid/ready handshake.
- Enforces a single frame in flight, an inter-byte timeout, and overrun reporting.

Parameters:
- OP_WIDTH, 8, operand width in bits (1..8); operand taken from rx_byte[OP_WIDTH-1:0], upper bits ignored.
- SETTLE_CYCLES, 2, cycles op_a/op_b are held stable before op_sum is sampled (1..15).
- TIMEOUT_CYCLES, 1200000, maximum idle cycles between operand A and operand B (100 ms at 12 MHz).

Ports:
- iCE_CLK in 1: system clock.
- RST in 1: synchronous, active-high reset.
- rx_valid in 1: one-cycle strobe, rx_byte is valid.
- rx_byte in 8: received byte.
- op_a out OP_WIDTH: adder operand A.
- op_b out OP_WIDTH: adder operand B.
- op_sum in OP_WIDTH: adder sum.
- op_cout in 1: adder carry out.
- tx_valid out 1: tx_byte is valid.
- tx_ready in 1: transmitter can accept a byte.
- tx_byte out 8: byte to transmit.
- busy out 1: high in any state other than IDLE.
- err_timeout out 1: one-cycle pulse when a frame is abandoned.
- err_overrun out 1: one-cycle pulse when an rx byte is dropped.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-frame discards everything; tx_valid drops in the same cycle RST is sampled.
- IDLE, on rx_valid: latch op_a; clear the timeout counter; go to GET_B.
- GET_B, on rx_valid: latch op_b; clear the settle counter; go to SETTLE.
- GET_B timeout: the timeout counter increments each cycle without rx_valid. When it reaches TIMEOUT_CYCLES-1 without rx_valid: pulse err_timeout, go to IDLE, op_a unchanged.
- GET_B, rx_valid in the same cycle the timeout would fire: the byte wins and no error is raised.
- SETTLE: count SETTLE_CYCLES cycles. On the last one, register result = {op_cout, op_sum} zero-extended to 9 bits, then go to SEND_SUM.
- Latency: first tx_valid rises exactly SETTLE_CYCLES+1 cycles after the rx_valid that delivered B.
- SEND_SUM: tx_valid=1, tx_byte = result[OP_WIDTH-1:0] zero-extended to 8 bits. Transfer occurs when tx_valid and tx_ready are both high.
- After the SEND_SUM transfer: go to SEND_FLAGS if the feature is enabled, else IDLE. tx_valid deasserts the cycle after the transfer.
- Handshake rules: tx_valid and tx_byte are stable until transferred and never depend combinationally on tx_ready. tx_ready may be high before tx_valid.
- op_a and op_b are held from capture until the next capture. They are never changed while in SETTLE or SEND_*.
- rx_valid in SETTLE, SEND_SUM or SEND_FLAGS: the byte is dropped and err_overrun pulses in the same cycle it is registered. The state is unaffected.
- Arithmetic: wrap is done by the external adder. The sequencer never modifies the sum; overflow appears only via op_cout.

Optional Feature:
- Macro UART_SEQ_FLAGS_BYTE_EN.
- Defined: after the sum byte, a SEND_FLAGS state transmits one flags byte, then returns to IDLE.
  - bit0 = carry.
  - bit1 = sum zero.
  - bit2 = a timeout occurred since the last flags byte (sticky, cleared on transfer).
  - bits7:3 = 0.
- Not defined: the SEND_FLAGS state and the sticky timeout bit are not synthesized. One byte per frame is transmitted.

Decomposition:
- Shared package uart_seq_pkg holds:
  - state encoding constants IDLE=0, GET_B=1, SETTLE=2, SEND_SUM=3, SEND_FLAGS=4 (3-bit);
  - flags byte bit positions;
  - the default clock frequency constant 12000000 used to derive TIMEOUT_CYCLES.
- One sub-module is natural: uart_seq_timer, a loadable down-counter with a terminal-count strobe. It is instantiated twice, once for timeout and once for settle.

Test Plan:
- Basic add (OP_WIDTH=4, SETTLE_CYCLES=2, tx_ready held high): rx 0x07 then 0x05 -> op_a=7, op_b=5, sum byte 0x0C appears 3 cycles after the second rx_valid; flags byte 0x00 when enabled.
- Carry (OP_WIDTH=8): rx 0xF0 then 0x20 with a stub adder -> tx 0x10, then flags 0x01.
- Backpressure: tx_ready low for 50 cycles -> tx_valid stays high with tx_byte stable; exactly one transfer occurs when tx_ready rises.
- Timeout (TIMEOUT_CYCLES=100): rx 0x03, then nothing -> err_timeout pulses on cycle 100 and busy falls. Next frame 0x01,0x01 -> 0x02; flags 0x04 when enabled.
- Overrun: a third rx byte during SETTLE -> err_overrun pulses once; the result is unchanged and no extra transmit occurs.
- Reset in SEND_SUM with tx_ready low: RST for 1 cycle -> tx_valid=0 and busy=0 next cycle; a fresh frame completes normally.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// -----------------------------------------------------------------------------
// uart_seq_pkg
// Shared definitions for the UART operand sequencer:
//   - seq_state_t : 3-bit FSM state encoding (IDLE, GET_B, SETTLE, SEND_SUM,
//                   SEND_FLAGS)
//   - FLAG_*_BIT  : bit positions inside the optional flags byte
//   - CLK_FREQ_HZ : board clock, used to derive the default inter-byte timeout
// -----------------------------------------------------------------------------
package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_B      = 3'd1,
        SETTLE     = 3'd2,
        SEND_SUM   = 3'd3,
        SEND_FLAGS = 3'd4
    } seq_state_t;

    // Flags byte layout (bits 7:3 are always zero)
    localparam int FLAG_CARRY_BIT   = 0;
    localparam int FLAG_ZERO_BIT    = 1;
    localparam int FLAG_TIMEOUT_BIT = 2;

    // iCE40 debugger board clock; the default timeout is 100 ms of it
    localparam int CLK_FREQ_HZ     = 12000000;
    localparam int TIMEOUT_DEFAULT = CLK_FREQ_HZ / 10;

endpackage

// File: rtl/uart_seq_timer.sv
// -----------------------------------------------------------------------------
// uart_seq_timer
// Loadable down-counter with a terminal-count strobe. The counter stops at
// zero; tc is high whenever the count is zero.
//
// Ports:
//   clk        in  : clock
//   rst        in  : synchronous active-high reset (count -> 0)
//   load       in  : load load_value (has priority over dec)
//   load_value in  : value to load
//   dec        in  : decrement by one when non-zero
//   tc         out : terminal count, high while count == 0
// -----------------------------------------------------------------------------
module uart_seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/uart_op_sequencer.sv
// -----------------------------------------------------------------------------
// uart_op_sequencer
// Sequences the UART-fed adder on the iCE40 debugger: collects operand A and
// operand B from the UART receiver, holds them on the external LUT/carry adder
// for SETTLE_CYCLES, captures {carry, sum}, and sends the sum byte (plus an
// optional flags byte) to the UART transmitter over valid/ready.
// Only one frame is in flight; bytes arriving while a frame is being settled
// or sent are dropped and reported on err_overrun. A missing operand B
// abandons the frame after TIMEOUT_CYCLES idle cycles (err_timeout).
//
// Build option:
//   UART_SEQ_FLAGS_BYTE_EN - when defined, a flags byte follows every sum byte:
//                            bit0 carry, bit1 sum==0, bit2 timeout occurred
//                            since the previous flags byte (sticky).
//
// Ports:
//   iCE_CLK     in  : system clock
//   RST         in  : synchronous active-high reset
//   rx_valid    in  : one-cycle strobe, rx_byte valid
//   rx_byte     in  : received byte (low OP_WIDTH bits used as operand)
//   op_a, op_b  out : adder operands, held between captures
//   op_sum      in  : adder sum
//   op_cout     in  : adder carry out
//   tx_valid    out : tx_byte valid
//   tx_ready    in  : transmitter accepts a byte
//   tx_byte     out : byte to transmit
//   busy        out : high whenever the FSM is not IDLE
//   err_timeout out : one-cycle pulse when a frame is abandoned
//   err_overrun out : one-cycle pulse when an rx byte is dropped
// -----------------------------------------------------------------------------
module uart_op_sequencer
    import uart_seq_pkg::*;
#(
    parameter int OP_WIDTH       = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                iCE_CLK,
    input  logic                RST,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic [OP_WIDTH-1:0] op_a,
    output logic [OP_WIDTH-1:0] op_b,
    input  logic [OP_WIDTH-1:0] op_sum,
    input  logic                op_cout,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_byte,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_overrun
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = 4;

    // Timers are loaded with N-1 so tc lands on the Nth cycle of the wait.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [OP_WIDTH:0] result;     // {carry, sum}

    logic capture_a;
    logic capture_b;
    logic capture_result;
    logic tmo_load;
    logic tmo_dec;
    logic tmo_tc;
    logic set_load;
    logic set_dec;
    logic set_tc;
    logic timeout_fire;
    logic overrun;
    logic tx_fire;

`ifdef UART_SEQ_FLAGS_BYTE_EN
    logic       flags_sent;
    logic       tmo_sticky;
    logic [7:0] flags_byte;
`else
    // Carry is consumed only by the flags byte; in this build it is dropped.
    logic carry_unused;
    assign carry_unused = result[OP_WIDTH];
`endif

    function automatic logic [7:0] zext8(input logic [OP_WIDTH-1:0] v);
        logic [7:0] b;
        b = '0;
        b[OP_WIDTH-1:0] = v;
        return b;
    endfunction

    uart_seq_timer #(.WIDTH(TMO_W)) u_timeout_timer (
        .clk        (iCE_CLK),
        .rst        (RST),
        .load       (tmo_load),
        .load_value (TMO_LOAD),
        .dec        (tmo_dec),
        .tc         (tmo_tc)
    );

    uart_seq_timer #(.WIDTH(SET_W)) u_settle_timer (
        .clk        (iCE_CLK),
        .rst        (RST),
        .load       (set_load),
        .load_value (SET_LOAD),
        .dec        (set_dec),
        .tc         (set_tc)
    );

    // tx_valid is decoded from the state register only, so it can never
    // depend combinationally on tx_ready.
    assign tx_valid = (state == SEND_SUM) || (state == SEND_FLAGS);
    assign busy     = (state != IDLE);
    assign tx_fire  = tx_valid && tx_ready;

    always_ff @(posedge iCE_CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        capture_a      = 1'b0;
        capture_b      = 1'b0;
        capture_result = 1'b0;
        tmo_load       = 1'b0;
        tmo_dec        = 1'b0;
        set_load       = 1'b0;
        set_dec        = 1'b0;
        timeout_fire   = 1'b0;
        overrun        = 1'b0;
`ifdef UART_SEQ_FLAGS_BYTE_EN
        flags_sent     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    capture_a  = 1'b1;
                    tmo_load   = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                // A byte arriving on the timeout cycle still completes the frame.
                if (rx_valid) begin
                    capture_b  = 1'b1;
                    set_load   = 1'b1;
                    state_next = SETTLE;
                end else if (tmo_tc) begin
                    timeout_fire = 1'b1;
                    state_next   = IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            SETTLE: begin
                overrun = rx_valid;
                if (set_tc) begin
                    capture_result = 1'b1;
                    state_next     = SEND_SUM;
                end else begin
                    set_dec = 1'b1;
                end
            end
            SEND_SUM: begin
                overrun = rx_valid;
                if (tx_fire) begin
`ifdef UART_SEQ_FLAGS_BYTE_EN
                    state_next = SEND_FLAGS;
`else
                    state_next = IDLE;
`endif
                end
            end
            SEND_FLAGS: begin
`ifdef UART_SEQ_FLAGS_BYTE_EN
                overrun = rx_valid;
                if (tx_fire) begin
                    flags_sent = 1'b1;
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands only change on a capture, so they stay put through SETTLE/SEND.
    always_ff @(posedge iCE_CLK) begin
        if (RST) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
        end else begin
            if (capture_a) begin
                op_a <= rx_byte[OP_WIDTH-1:0];
            end
            if (capture_b) begin
                op_b <= rx_byte[OP_WIDTH-1:0];
            end
            if (capture_result) begin
                result <= {op_cout, op_sum};
            end
        end
    end

    always_ff @(posedge iCE_CLK) begin
        if (RST) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= timeout_fire;
            err_overrun <= overrun;
        end
    end

`ifdef UART_SEQ_FLAGS_BYTE_EN
    always_ff @(posedge iCE_CLK) begin
        if (RST) begin
            tmo_sticky <= 1'b0;
        end else if (timeout_fire) begin
            tmo_sticky <= 1'b1;
        end else if (flags_sent) begin
            tmo_sticky <= 1'b0;
        end
    end

    always_comb begin
        flags_byte                   = '0;
        flags_byte[FLAG_CARRY_BIT]   = result[OP_WIDTH];
        flags_byte[FLAG_ZERO_BIT]    = (result[OP_WIDTH-1:0] == '0);
        flags_byte[FLAG_TIMEOUT_BIT] = tmo_sticky;
    end
`endif

    always_comb begin
        tx_byte = '0;
        case (state)
            SEND_SUM:   tx_byte = zext8(result[OP_WIDTH-1:0]);
`ifdef UART_SEQ_FLAGS_BYTE_EN
            SEND_FLAGS: tx_byte = flags_byte;
`endif
            default:    tx_byte = '0;
        endcase
    end

endmodule
